// File: rtl/lsb_queue_pkg.sv
// Shared types and constants for the load/store buffer.
// Widths, funct3 encodings, memory size codes and the issue FSM states.
package lsb_queue_pkg;

   localparam int ROB_WID  = 4;
   localparam int DATA_WID = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_e;

   function automatic logic [1:0] f3_size(input logic [2:0] f3);
      return f3[1:0];
   endfunction

endpackage

// File: rtl/lsb_load_align.sv
// Load data extension: picks byte/half/word from raw memory data
// and sign- or zero-extends it according to funct3.
module lsb_load_align
   import lsb_queue_pkg::*;
#(
   parameter int XLEN = DATA_WID
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] raw,
   output logic [XLEN-1:0] val
);

   always_comb begin
      val = raw;
      case (funct3)
         F3_LB:   val = {{(XLEN-8){raw[7]}}, raw[7:0]};
         F3_LH:   val = {{(XLEN-16){raw[15]}}, raw[15:0]};
         F3_LBU:  val = {{(XLEN-8){1'b0}}, raw[7:0]};
         F3_LHU:  val = {{(XLEN-16){1'b0}}, raw[15:0]};
         default: val = raw;
      endcase
   end

endmodule

// File: rtl/lsb_queue.sv
// In-order load/store buffer: CDB wakeup, head-only memory issue.
// Optional LSB_MMIO_GUARD_EN holds MMIO loads until they reach ROB head.
module lsb_queue
   import lsb_queue_pkg::*;
#(
   parameter int              DEPTH   = 16,
   parameter int              ROB_W   = ROB_WID,
   parameter int              XLEN    = DATA_WID,
   parameter logic [XLEN-1:0] IO_BASE = 32'h30000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             rollback,
   output logic             lsb_full,
   input  logic             disp_en,
   input  logic [ROB_W-1:0] disp_rob_pos,
   input  logic             disp_is_store,
   input  logic [2:0]       disp_funct3,
   input  logic             disp_rs1_rdy,
   input  logic [XLEN-1:0]  disp_rs1_val,
   input  logic [ROB_W-1:0] disp_rs1_tag,
   input  logic             disp_rs2_rdy,
   input  logic [XLEN-1:0]  disp_rs2_val,
   input  logic [ROB_W-1:0] disp_rs2_tag,
   input  logic [XLEN-1:0]  disp_imm,
   input  logic             cdb_alu_en,
   input  logic [ROB_W-1:0] cdb_alu_pos,
   input  logic [XLEN-1:0]  cdb_alu_val,
   input  logic             cdb_lsb_en,
   input  logic [ROB_W-1:0] cdb_lsb_pos,
   input  logic [XLEN-1:0]  cdb_lsb_val,
   input  logic             commit_store_en,
   input  logic [ROB_W-1:0] commit_rob_pos,
   input  logic [ROB_W-1:0] rob_head_pos,
   output logic             mem_req,
   output logic             mem_wr,
   output logic [XLEN-1:0]  mem_addr,
   output logic [XLEN-1:0]  mem_wdata,
   output logic [1:0]       mem_size,
   input  logic             mem_done,
   input  logic [XLEN-1:0]  mem_rdata,
   output logic             res_en,
   output logic [ROB_W-1:0] res_rob_pos,
   output logic [XLEN-1:0]  res_val
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic             valid;
      logic             is_store;
      logic             cmt;
      logic [2:0]       funct3;
      logic [ROB_W-1:0] rob_pos;
      logic             rs1_rdy;
      logic [XLEN-1:0]  rs1_val;
      logic [ROB_W-1:0] rs1_tag;
      logic             rs2_rdy;
      logic [XLEN-1:0]  rs2_val;
      logic [ROB_W-1:0] rs2_tag;
      logic [XLEN-1:0]  imm;
   } ent_t;

   ent_t             ent_q [DEPTH];
   ent_t             ent_d [DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   state_e           state_q, state_d;
   logic             kill_q, kill_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_wr_q, mem_wr_d;
   logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;
   logic [1:0]       mem_size_q, mem_size_d;
   logic             res_en_q, res_en_d;
   logic [ROB_W-1:0] res_pos_q, res_pos_d;
   logic [XLEN-1:0]  res_val_q, res_val_d;

   ent_t             hd;
   ent_t             nw;
   logic [XLEN-1:0]  ea;
   logic [XLEN-1:0]  ld_val;
   logic             mmio_ok;
   logic             go;
   logic             inc;
   logic             dec;
   logic             keep;
   logic [CW-1:0]    kept;

   assign hd = ent_q[head_q];
   assign ea = hd.rs1_val + hd.imm;

`ifdef LSB_MMIO_GUARD_EN
   assign mmio_ok = (ea < IO_BASE) || (hd.rob_pos == rob_head_pos);
`else
   logic unused_guard;
   assign unused_guard = ^{rob_head_pos, IO_BASE};
   assign mmio_ok = 1'b1;
`endif

   lsb_load_align #(.XLEN(XLEN)) u_align (
      .funct3 (hd.funct3),
      .raw    (mem_rdata),
      .val    (ld_val)
   );

   // A load on the rollback edge is wrong-path; only committed stores may go.
   always_comb begin
      go = 1'b0;
      if (hd.valid && hd.rs1_rdy) begin
         if (hd.is_store) go = hd.rs2_rdy && hd.cmt;
         else             go = mmio_ok && !rollback;
      end
   end

   always_comb begin
      nw          = '0;
      nw.valid    = 1'b1;
      nw.is_store = disp_is_store;
      nw.funct3   = disp_funct3;
      nw.rob_pos  = disp_rob_pos;
      nw.imm      = disp_imm;
      nw.rs1_tag  = disp_rs1_tag;
      nw.rs2_tag  = disp_rs2_tag;
      nw.rs1_rdy  = disp_rs1_rdy;
      nw.rs1_val  = disp_rs1_val;
      nw.rs2_rdy  = disp_rs2_rdy;
      nw.rs2_val  = disp_rs2_val;
      if (!disp_rs1_rdy) begin
         if (cdb_alu_en && cdb_alu_pos == disp_rs1_tag) begin
            nw.rs1_rdy = 1'b1;
            nw.rs1_val = cdb_alu_val;
         end else if (cdb_lsb_en && cdb_lsb_pos == disp_rs1_tag) begin
            nw.rs1_rdy = 1'b1;
            nw.rs1_val = cdb_lsb_val;
         end
      end
      if (!disp_rs2_rdy) begin
         if (cdb_alu_en && cdb_alu_pos == disp_rs2_tag) begin
            nw.rs2_rdy = 1'b1;
            nw.rs2_val = cdb_alu_val;
         end else if (cdb_lsb_en && cdb_lsb_pos == disp_rs2_tag) begin
            nw.rs2_rdy = 1'b1;
            nw.rs2_val = cdb_lsb_val;
         end
      end
   end

   always_comb begin
      ent_d       = ent_q;
      head_d      = head_q;
      tail_d      = tail_q;
      cnt_d       = cnt_q;
      state_d     = state_q;
      kill_d      = kill_q;
      mem_req_d   = mem_req_q;
      mem_wr_d    = mem_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_size_d  = mem_size_q;
      res_en_d    = 1'b0;
      res_pos_d   = res_pos_q;
      res_val_d   = res_val_q;
      inc         = 1'b0;
      dec         = 1'b0;
      keep        = 1'b0;
      kept        = '0;

      for (int i = 0; i < DEPTH; i++) begin
         if (ent_q[i].valid) begin
            if (!ent_q[i].rs1_rdy) begin
               if (cdb_alu_en && cdb_alu_pos == ent_q[i].rs1_tag) begin
                  ent_d[i].rs1_rdy = 1'b1;
                  ent_d[i].rs1_val = cdb_alu_val;
               end else if (cdb_lsb_en && cdb_lsb_pos == ent_q[i].rs1_tag) begin
                  ent_d[i].rs1_rdy = 1'b1;
                  ent_d[i].rs1_val = cdb_lsb_val;
               end
            end
            if (!ent_q[i].rs2_rdy) begin
               if (cdb_alu_en && cdb_alu_pos == ent_q[i].rs2_tag) begin
                  ent_d[i].rs2_rdy = 1'b1;
                  ent_d[i].rs2_val = cdb_alu_val;
               end else if (cdb_lsb_en && cdb_lsb_pos == ent_q[i].rs2_tag) begin
                  ent_d[i].rs2_rdy = 1'b1;
                  ent_d[i].rs2_val = cdb_lsb_val;
               end
            end
            if (commit_store_en && ent_q[i].is_store &&
                ent_q[i].rob_pos == commit_rob_pos) begin
               ent_d[i].cmt = 1'b1;
            end
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (go) begin
               mem_req_d   = 1'b1;
               mem_wr_d    = hd.is_store;
               mem_addr_d  = ea;
               mem_wdata_d = hd.rs2_val;
               mem_size_d  = f3_size(hd.funct3);
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_done) begin
               mem_req_d            = 1'b0;
               ent_d[head_q].valid  = 1'b0;
               ent_d[head_q].cmt    = 1'b0;
               head_d               = head_q + PW'(1);
               dec                  = 1'b1;
               state_d              = S_IDLE;
               kill_d               = 1'b0;
               if (!hd.is_store && !kill_q && !rollback) begin
                  res_en_d  = 1'b1;
                  res_pos_d = hd.rob_pos;
                  res_val_d = ld_val;
               end
            end
         end
      endcase

      // The in-flight head keeps its slot until its mem_done frees it.
      if (rollback) begin
         for (int i = 0; i < DEPTH; i++) begin
            keep = ent_d[i].valid &&
                   (ent_d[i].cmt ||
                    (state_q == S_WAIT && !mem_done && PW'(i) == head_q));
            if (keep) begin
               kept = kept + CW'(1);
            end else begin
               ent_d[i].valid = 1'b0;
               ent_d[i].cmt   = 1'b0;
            end
         end
         tail_d = head_d + kept[PW-1:0];
         cnt_d  = kept;
         if (state_q == S_WAIT && !mem_done && !hd.is_store) kill_d = 1'b1;
      end else begin
         if (disp_en) begin
            ent_d[tail_q] = nw;
            tail_d        = tail_q + PW'(1);
            inc           = 1'b1;
         end
         cnt_d = cnt_q + CW'(inc) - CW'(dec);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         cnt_q       <= '0;
         state_q     <= S_IDLE;
         kill_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_size_q  <= '0;
         res_en_q    <= 1'b0;
         res_pos_q   <= '0;
         res_val_q   <= '0;
      end else if (rdy) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
         head_q      <= head_d;
         tail_q      <= tail_d;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         kill_q      <= kill_d;
         mem_req_q   <= mem_req_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_size_q  <= mem_size_d;
         res_en_q    <= res_en_d;
         res_pos_q   <= res_pos_d;
         res_val_q   <= res_val_d;
      end
   end

   assign lsb_full    = (cnt_q >= CW'(DEPTH - 1));
   assign mem_req     = mem_req_q;
   assign mem_wr      = mem_wr_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_size    = mem_size_q;
   assign res_en      = res_en_q;
   assign res_rob_pos = res_pos_q;
   assign res_val     = res_val_q;

endmodule

// File: tb/tb_lsb_queue.sv
// Scoreboard bench for lsb_queue: directed stimulus pushes expected
// memory requests and load results, a monitor pops and compares them.
module tb_lsb_queue;
   import lsb_queue_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback, lsb_full;
   logic        disp_en, disp_is_store, disp_rs1_rdy, disp_rs2_rdy;
   logic [3:0]  disp_rob_pos, disp_rs1_tag, disp_rs2_tag;
   logic [2:0]  disp_funct3;
   logic [31:0] disp_rs1_val, disp_rs2_val, disp_imm;
   logic        cdb_alu_en, cdb_lsb_en, commit_store_en;
   logic [3:0]  cdb_alu_pos, cdb_lsb_pos, commit_rob_pos, rob_head_pos;
   logic [31:0] cdb_alu_val, cdb_lsb_val;
   logic        mem_req, mem_wr, mem_done, res_en;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, res_val;
   logic [1:0]  mem_size;
   logic [3:0]  res_rob_pos;

   always #5 clk = ~clk;

   lsb_queue dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .lsb_full(lsb_full), .disp_en(disp_en),
      .disp_rob_pos(disp_rob_pos), .disp_is_store(disp_is_store),
      .disp_funct3(disp_funct3),
      .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val),
      .disp_rs1_tag(disp_rs1_tag),
      .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_val(disp_rs2_val),
      .disp_rs2_tag(disp_rs2_tag), .disp_imm(disp_imm),
      .cdb_alu_en(cdb_alu_en), .cdb_alu_pos(cdb_alu_pos),
      .cdb_alu_val(cdb_alu_val),
      .cdb_lsb_en(cdb_lsb_en), .cdb_lsb_pos(cdb_lsb_pos),
      .cdb_lsb_val(cdb_lsb_val),
      .commit_store_en(commit_store_en), .commit_rob_pos(commit_rob_pos),
      .rob_head_pos(rob_head_pos),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_size(mem_size),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .res_en(res_en), .res_rob_pos(res_rob_pos), .res_val(res_val)
   );

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
   } mreq_t;

   typedef struct packed {
      logic [3:0]  pos;
      logic [31:0] val;
   } res_t;

   mreq_t exp_mem[$];
   res_t  exp_res[$];
   int    checks   = 0;
   int    failures = 0;
   bit    req_seen = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_req && !req_seen) begin
         req_seen = 1'b1;
         if (exp_mem.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mem_unexpected: got req addr %h want none", mem_addr);
         end else begin
            mreq_t e;
            e = exp_mem.pop_front();
            chk("mem_wr", 32'(mem_wr), 32'(e.wr));
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_size", 32'(mem_size), 32'(e.size));
            if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
         end
      end
      if (!mem_req) req_seen = 1'b0;
      if (res_en) begin
         if (exp_res.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL res_unexpected: got pos %0d val %h want none",
                     res_rob_pos, res_val);
         end else begin
            res_t r;
            r = exp_res.pop_front();
            chk("res_pos", 32'(res_rob_pos), 32'(r.pos));
            chk("res_val", res_val, r.val);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic disp(input logic [3:0] rob, input logic st,
                       input logic [2:0] f3,
                       input logic r1, input logic [31:0] v1,
                       input logic [3:0] t1,
                       input logic r2, input logic [31:0] v2,
                       input logic [3:0] t2, input logic [31:0] imm);
      disp_en       = 1'b1;
      disp_rob_pos  = rob;
      disp_is_store = st;
      disp_funct3   = f3;
      disp_rs1_rdy  = r1;
      disp_rs1_val  = v1;
      disp_rs1_tag  = t1;
      disp_rs2_rdy  = r2;
      disp_rs2_val  = v2;
      disp_rs2_tag  = t2;
      disp_imm      = imm;
      step();
      disp_en = 1'b0;
   endtask

   task automatic ld(input logic [3:0] rob, input logic [2:0] f3,
                     input logic [31:0] base, input logic [31:0] imm);
      disp(rob, 1'b0, f3, 1'b1, base, 4'd0, 1'b1, 32'd0, 4'd0, imm);
   endtask

   task automatic wait_req();
      int n = 0;
      while (!mem_req && n < 50) begin
         step();
         n++;
      end
      if (!mem_req) begin
         checks++;
         failures++;
         $display("FAIL req_timeout: got mem_req 0 want 1");
      end
   endtask

   task automatic complete(input logic [31:0] rd);
      wait_req();
      mem_done  = 1'b1;
      mem_rdata = rd;
      step();
      mem_done  = 1'b0;
      mem_rdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
      disp_en = 1'b0; disp_rob_pos = '0; disp_is_store = 1'b0;
      disp_funct3 = '0; disp_rs1_rdy = 1'b0; disp_rs1_val = '0;
      disp_rs1_tag = '0; disp_rs2_rdy = 1'b0; disp_rs2_val = '0;
      disp_rs2_tag = '0; disp_imm = '0;
      cdb_alu_en = 1'b0; cdb_alu_pos = '0; cdb_alu_val = '0;
      cdb_lsb_en = 1'b0; cdb_lsb_pos = '0; cdb_lsb_val = '0;
      commit_store_en = 1'b0; commit_rob_pos = '0; rob_head_pos = '0;
      mem_done = 1'b0; mem_rdata = '0;
      idle(2);
      rst = 1'b0;
      chk("rst_full", 32'(lsb_full), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_res", 32'(res_en), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_rval", res_val, 32'd0);

      // LW latency and full word
      exp_mem.push_back('{1'b0, 32'h1004, 32'h0, SZ_W});
      exp_res.push_back('{4'd1, 32'hCAFEF00D});
      ld(4'd1, F3_LW, 32'h1000, 32'd4);
      chk("lw_lat0", 32'(mem_req), 32'd0);
      step();
      chk("lw_lat1", 32'(mem_req), 32'd1);
      complete(32'hCAFEF00D);
      chk("lw_res_lat", 32'(res_en), 32'd1);
      chk("lw_req_drop", 32'(mem_req), 32'd0);

      // byte/half extension, negative offset
      exp_mem.push_back('{1'b0, 32'h1004, 32'h0, SZ_B});
      exp_res.push_back('{4'd2, 32'h00000080});
      ld(4'd2, F3_LBU, 32'h1000, 32'd4);
      complete(32'h00000080);
      exp_mem.push_back('{1'b0, 32'h1004, 32'h0, SZ_B});
      exp_res.push_back('{4'd3, 32'hFFFFFF80});
      ld(4'd3, F3_LB, 32'h1000, 32'd4);
      complete(32'h00000080);
      exp_mem.push_back('{1'b0, 32'h0FFE, 32'h0, SZ_H});
      exp_res.push_back('{4'd4, 32'hFFFF8001});
      ld(4'd4, F3_LH, 32'h1000, 32'hFFFFFFFE);
      complete(32'h12348001);
      exp_mem.push_back('{1'b0, 32'h0FFE, 32'h0, SZ_H});
      exp_res.push_back('{4'd5, 32'h00008001});
      ld(4'd5, F3_LHU, 32'h1000, 32'hFFFFFFFE);
      complete(32'h12348001);

      // dispatch snoops same-cycle CDB
      exp_mem.push_back('{1'b0, 32'h48, 32'h0, SZ_W});
      exp_res.push_back('{4'd6, 32'h0BADBEEF});
      cdb_lsb_en = 1'b1; cdb_lsb_pos = 4'd7; cdb_lsb_val = 32'h40;
      disp(4'd6, 1'b0, F3_LW, 1'b0, 32'h0, 4'd7, 1'b1, 32'h0, 4'd0, 32'd8);
      cdb_lsb_en = 1'b0;
      complete(32'h0BADBEEF);
      idle(2);

      // store waits for data and commit
      disp(4'd6, 1'b1, F3_SW, 1'b1, 32'h2000, 4'd0, 1'b0, 32'h0, 4'd3, 32'd0);
      idle(2);
      cdb_alu_en = 1'b1; cdb_alu_pos = 4'd3; cdb_alu_val = 32'hDEAD;
      step();
      cdb_alu_en = 1'b0;
      idle(3);
      chk("sw_hold", 32'(mem_req), 32'd0);
      exp_mem.push_back('{1'b1, 32'h2000, 32'hDEAD, SZ_W});
      commit_store_en = 1'b1; commit_rob_pos = 4'd6;
      step();
      commit_store_en = 1'b0;
      complete(32'h0);
      chk("sw_nores", 32'(res_en), 32'd0);

      // rdy low freezes issue
      exp_mem.push_back('{1'b0, 32'h1200, 32'h0, SZ_W});
      exp_res.push_back('{4'd7, 32'h00001234});
      ld(4'd7, F3_LW, 32'h1200, 32'd0);
      rdy = 1'b0;
      idle(3);
      chk("rdy_freeze", 32'(mem_req), 32'd0);
      rdy = 1'b1;
      step();
      chk("rdy_resume", 32'(mem_req), 32'd1);
      complete(32'h00001234);

      // fill to DEPTH-1, then free + dispatch on one edge
      exp_mem.push_back('{1'b0, 32'h100, 32'h0, SZ_W});
      exp_res.push_back('{4'd8, 32'h77});
      ld(4'd8, F3_LW, 32'h100, 32'd0);
      for (int i = 0; i < 13; i++)
         disp(4'd10, 1'b0, F3_LW, 1'b0, 32'h0, 4'd9, 1'b1, 32'h0, 4'd0, 32'd0);
      chk("fill14_full", 32'(lsb_full), 32'd0);
      disp(4'd10, 1'b0, F3_LW, 1'b0, 32'h0, 4'd9, 1'b1, 32'h0, 4'd0, 32'd0);
      chk("fill15_full", 32'(lsb_full), 32'd1);
      wait_req();
      mem_done = 1'b1; mem_rdata = 32'h77;
      disp(4'd10, 1'b0, F3_LW, 1'b0, 32'h0, 4'd9, 1'b1, 32'h0, 4'd0, 32'd0);
      mem_done = 1'b0;
      chk("swap_full", 32'(lsb_full), 32'd1);
      step();
      chk("swap_full2", 32'(lsb_full), 32'd1);
      rollback = 1'b1;
      step();
      rollback = 1'b0;
      chk("flush_full", 32'(lsb_full), 32'd0);
      idle(3);
      chk("flush_noreq", 32'(mem_req), 32'd0);

      // rollback with in-flight load and committed stores
      exp_mem.push_back('{1'b0, 32'h300, 32'h0, SZ_W});
      ld(4'd1, F3_LW, 32'h300, 32'd0);
      disp(4'd2, 1'b1, F3_SW, 1'b1, 32'h400, 4'd0, 1'b1, 32'h11, 4'd0, 32'd0);
      disp(4'd3, 1'b1, F3_SW, 1'b1, 32'h404, 4'd0, 1'b1, 32'h22, 4'd0, 32'd0);
      ld(4'd4, F3_LW, 32'h500, 32'd0);
      ld(4'd5, F3_LW, 32'h504, 32'd0);
      commit_store_en = 1'b1; commit_rob_pos = 4'd2;
      step();
      commit_rob_pos = 4'd3;
      step();
      commit_store_en = 1'b0;
      wait_req();
      rollback = 1'b1;
      disp(4'd11, 1'b0, F3_LW, 1'b1, 32'h600, 4'd0, 1'b1, 32'h0, 4'd0, 32'd0);
      rollback = 1'b0;
      chk("rb_full", 32'(lsb_full), 32'd0);
      exp_mem.push_back('{1'b1, 32'h400, 32'h11, SZ_W});
      exp_mem.push_back('{1'b1, 32'h404, 32'h22, SZ_W});
      complete(32'h99);
      chk("rb_nores", 32'(res_en), 32'd0);
      complete(32'h0);
      complete(32'h0);
      idle(4);
      chk("rb_drained", 32'(mem_req), 32'd0);

`ifdef LSB_MMIO_GUARD_EN
      exp_mem.push_back('{1'b0, 32'h30000, 32'h0, SZ_W});
      exp_res.push_back('{4'd2, 32'h5});
      rob_head_pos = 4'd0;
      ld(4'd2, F3_LW, 32'h30000, 32'd0);
      idle(4);
      chk("mmio_hold", 32'(mem_req), 32'd0);
      rob_head_pos = 4'd2;
      step();
      step();
      chk("mmio_go", 32'(mem_req), 32'd1);
      complete(32'h5);
      rob_head_pos = 4'd0;
      idle(2);
`endif

      // reset while waiting on memory
      exp_mem.push_back('{1'b0, 32'h700, 32'h0, SZ_W});
      ld(4'd9, F3_LW, 32'h700, 32'd0);
      wait_req();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstw_req", 32'(mem_req), 32'd0);
      chk("rstw_full", 32'(lsb_full), 32'd0);
      idle(3);
      chk("rstw_idle", 32'(mem_req), 32'd0);
      chk("rstw_res", 32'(res_en), 32'd0);

      chk("mem_drained", 32'(exp_mem.size()), 32'd0);
      chk("res_drained", 32'(exp_res.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
